// File: rtl/fixed_point_vec_mul.sv
// Element-wise fixed-point vector multiplier built around one shared signed
// multiplier that walks the elements one per cycle. Products collect in a
// scratch buffer and are copied to the outputs in one step on completion, so
// VALUES_OUT stays stable while the downstream accumulator reads it.
// Optional build macro: FIXED_POINT_VEC_MUL_SATURATE_EN (clamp on overflow;
// wrap-around when undefined).
module fixed_point_vec_mul #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FRAC_BITS  = 3,
   parameter int unsigned NUM_INPUTS = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_INPUTS*WIDTH-1:0]   VALUES_IN,
   input  logic [NUM_INPUTS*WIDTH-1:0]   WEIGHTS_IN,
   input  logic                          VALID_IN,
   output logic                          READY_OUT,
   output logic [NUM_INPUTS*WIDTH-1:0]   VALUES_OUT,
   output logic                          VALID_OUT,
   output logic [NUM_INPUTS-1:0]         OVF_MASK_OUT,
   output logic                          OVERFLOW
);

   localparam int unsigned BUS_W  = NUM_INPUTS * WIDTH;
   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
`ifdef FIXED_POINT_VEC_MUL_SATURATE_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic {IDLE, MUL} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [BUS_W-1:0]       a_q, w_q;
   logic [BUS_W-1:0]       scratch_q, scratch_d;
   logic [NUM_INPUTS-1:0]  scr_ovf_q, scr_ovf_d;
   logic                   load, step, done;

   logic signed [WIDTH-1:0]  op_a, op_w;
   logic signed [PROD_W-1:0] prod, shifted;
   logic                     elem_ovf;
   logic [WIDTH-1:0]         elem_res;

   // Shared multiplier: product, floor shift, range check, store policy
   always_comb begin
      op_a     = a_q[idx_q*WIDTH +: WIDTH];
      op_w     = w_q[idx_q*WIDTH +: WIDTH];
      prod     = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) *
                 $signed({{WIDTH{op_w[WIDTH-1]}}, op_w});
      shifted  = prod >>> FRAC_BITS;
      // in range only when all bits from the result sign bit upward agree
      elem_ovf = !((&shifted[PROD_W-1:WIDTH-1]) || !(|shifted[PROD_W-1:WIDTH-1]));
`ifdef FIXED_POINT_VEC_MUL_SATURATE_EN
      if (elem_ovf)
         elem_res = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
      else
         elem_res = shifted[WIDTH-1:0];
`else
      elem_res = shifted[WIDTH-1:0];
`endif
   end

   // Scratch buffer with the current element merged in
   always_comb begin
      scratch_d = scratch_q;
      scr_ovf_d = scr_ovf_q;
      scratch_d[idx_q*WIDTH +: WIDTH] = elem_res;
      scr_ovf_d[idx_q]                = elem_ovf;
   end

   // Next-state and control decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      step    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (VALID_IN) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            step  = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               done    = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, index and ready registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         READY_OUT <= 1'b1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         READY_OUT <= (state_d == IDLE);
      end
   end

   // Operand latch, scratch buffer and double-buffered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_q          <= '0;
         w_q          <= '0;
         scratch_q    <= '0;
         scr_ovf_q    <= '0;
         VALUES_OUT   <= '0;
         OVF_MASK_OUT <= '0;
         OVERFLOW     <= 1'b0;
         VALID_OUT    <= 1'b0;
      end else begin
         VALID_OUT <= done;
         if (load) begin
            a_q       <= VALUES_IN;
            w_q       <= WEIGHTS_IN;
            scr_ovf_q <= '0;
         end
         if (step) begin
            scratch_q <= scratch_d;
            scr_ovf_q <= scr_ovf_d;
         end
         if (done) begin
            VALUES_OUT   <= scratch_d;
            OVF_MASK_OUT <= scr_ovf_d;
            OVERFLOW     <= |scr_ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_fixed_point_vec_mul.sv
// Directed self-checking bench for fixed_point_vec_mul (WIDTH=8, FRAC_BITS=3,
// NUM_INPUTS=16).
module tb_fixed_point_vec_mul;

   localparam int N = 16;
   localparam int W = 8;

   logic           CLK = 1'b0;
   logic           RST;
   logic [N*W-1:0] VALUES_IN, WEIGHTS_IN;
   logic           VALID_IN;
   logic           READY_OUT;
   logic [N*W-1:0] VALUES_OUT;
   logic           VALID_OUT;
   logic [N-1:0]   OVF_MASK_OUT;
   logic           OVERFLOW;

   fixed_point_vec_mul #(.WIDTH(W), .FRAC_BITS(3), .NUM_INPUTS(N)) dut (
      .CLK(CLK), .RST(RST), .VALUES_IN(VALUES_IN), .WEIGHTS_IN(WEIGHTS_IN),
      .VALID_IN(VALID_IN), .READY_OUT(READY_OUT), .VALUES_OUT(VALUES_OUT),
      .VALID_OUT(VALID_OUT), .OVF_MASK_OUT(OVF_MASK_OUT), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int lat, rlow;
   logic signed [W-1:0] av [N];
   logic signed [W-1:0] wv [N];
   logic [N*W-1:0] exp_bus;
   logic [N-1:0]   exp_mask;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Reference: full product, floor shift, range check, store policy
   function automatic logic [W-1:0] model(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] w,
                                          output logic o);
      int p, r;
      p = int'(a) * int'(w);
      r = p >>> 3;
      o = (r > 127) || (r < -128);
`ifdef FIXED_POINT_VEC_MUL_SATURATE_EN
      if (r > 127) return 8'h7F;
      if (r < -128) return 8'h80;
`endif
      return 8'(r);
   endfunction

   task automatic set_inputs;
      logic o;
      for (int i = 0; i < N; i++) begin
         VALUES_IN[i*W +: W]  = av[i];
         WEIGHTS_IN[i*W +: W] = wv[i];
         exp_bus[i*W +: W]    = model(av[i], wv[i], o);
         exp_mask[i]          = o;
      end
   endtask

   // Accept one vector, then wait (bounded) for VALID_OUT
   task automatic run_vec(input bit rnd);
      VALID_IN = 1'b1;
      tick;
      VALID_IN = 1'b0;
      lat = 0;
      rlow = 0;
      while (VALID_OUT !== 1'b1 && lat < 40) begin
         if (READY_OUT === 1'b0) rlow++;
         if (rnd) begin
            VALUES_IN  = {$urandom, $urandom, $urandom, $urandom};
            WEIGHTS_IN = {$urandom, $urandom, $urandom, $urandom};
         end
         tick;
         lat++;
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      VALID_IN = 1'b0;
      VALUES_IN = '0;
      WEIGHTS_IN = '0;
      tick;
      tick;
      checks++;
      if (VALUES_OUT !== '0 || OVF_MASK_OUT !== '0 || OVERFLOW !== 1'b0 ||
          VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: vals=%h mask=%h ovf=%b vld=%b rdy=%b, want 0/0/0/0/1",
                  VALUES_OUT, OVF_MASK_OUT, OVERFLOW, VALID_OUT, READY_OUT);
      end
      RST = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      for (int i = 0; i < N; i++) begin av[i] = 8'sd12; wv[i] = 8'sd16; end
      set_inputs;
      run_vec(1'b0);
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
      checks++;
      if (rlow !== 16) begin errors++; $display("FAIL basic_ready_low: got %0d want 16", rlow); end
      checks++;
      if (VALUES_OUT !== {N{8'd24}}) begin
         errors++; $display("FAIL basic_values: got %h want all 18", VALUES_OUT);
      end
      checks++;
      if (OVERFLOW !== 1'b0 || OVF_MASK_OUT !== '0) begin
         errors++; $display("FAIL basic_ovf: got %b/%h want 0/0", OVERFLOW, OVF_MASK_OUT);
      end
      tick;
      checks++;
      if (VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
         errors++; $display("FAIL basic_pulse_width: vld=%b rdy=%b want 0/1", VALID_OUT, READY_OUT);
      end
   endtask

   task automatic test_sign;
      for (int i = 0; i < N; i++) begin av[i] = '0; wv[i] = '0; end
      av[0] = -8'sd12; wv[0] = 8'sd16;
      av[1] = -8'sd1;  wv[1] = 8'sd1;
      av[2] = 8'sd1;   wv[2] = 8'sd1;
      set_inputs;
      run_vec(1'b0);
      checks++;
      if (VALUES_OUT[0 +: 8] !== 8'hE8) begin
         errors++; $display("FAIL sign_neg: got %h want e8", VALUES_OUT[0 +: 8]);
      end
      checks++;
      if (VALUES_OUT[8 +: 8] !== 8'hFF) begin
         errors++; $display("FAIL sign_floor: got %h want ff", VALUES_OUT[8 +: 8]);
      end
      checks++;
      if (VALUES_OUT[N*W-1:16] !== '0 || VALUES_OUT !== exp_bus) begin
         errors++; $display("FAIL sign_rest: got %h want %h", VALUES_OUT, exp_bus);
      end
   endtask

   task automatic test_overflow;
      logic [W-1:0] want5;
`ifdef FIXED_POINT_VEC_MUL_SATURATE_EN
      want5 = 8'h7F;
`else
      want5 = 8'hFE;
`endif
      for (int i = 0; i < N; i++) begin av[i] = 8'sd8; wv[i] = 8'sd8; end
      av[5] = 8'sd127; wv[5] = 8'sd16;
      set_inputs;
      run_vec(1'b0);
      checks++;
      if (VALUES_OUT[40 +: 8] !== want5) begin
         errors++; $display("FAIL ovf_elem5: got %h want %h", VALUES_OUT[40 +: 8], want5);
      end
      checks++;
      if (OVF_MASK_OUT !== 16'h0020 || OVERFLOW !== 1'b1) begin
         errors++; $display("FAIL ovf_mask: got %h/%b want 0020/1", OVF_MASK_OUT, OVERFLOW);
      end
      checks++;
      if (VALUES_OUT !== exp_bus) begin
         errors++; $display("FAIL ovf_values: got %h want %h", VALUES_OUT, exp_bus);
      end
      tick;
      for (int i = 0; i < N; i++) begin av[i] = 8'sd12; wv[i] = 8'sd16; end
      set_inputs;
      run_vec(1'b0);
      checks++;
      if (OVF_MASK_OUT !== '0 || OVERFLOW !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: got %h/%b want 0000/0", OVF_MASK_OUT, OVERFLOW);
      end
   endtask

   task automatic test_back_to_back;
      logic [N*W-1:0] exp_a;
      int k, pulses;
      bit stable;
      tick;
      for (int i = 0; i < N; i++) begin av[i] = 8'(i); wv[i] = 8'sd24; end
      set_inputs;
      exp_a = exp_bus;
      VALID_IN = 1'b1;
      tick;
      k = 0;
      pulses = 0;
      while (VALID_OUT !== 1'b1 && k < 40) begin
         VALID_IN = (k == 4);
         if (k == 4) VALUES_IN = {N{8'h7F}};
         tick;
         k++;
      end
      VALID_IN = 1'b0;
      checks++;
      if (k !== 16 || VALUES_OUT !== exp_a) begin
         errors++; $display("FAIL b2b_first: lat=%0d got %h want lat 16 %h", k, VALUES_OUT, exp_a);
      end
      checks++;
      if (READY_OUT !== 1'b1) begin
         errors++; $display("FAIL b2b_ready_at_done: got %b want 1", READY_OUT);
      end
      for (int i = 0; i < N; i++) begin av[i] = -8'sd20; wv[i] = 8'(i + 1); end
      set_inputs;
      VALID_IN = 1'b1;
      tick;
      VALID_IN = 1'b0;
      k = 0;
      stable = 1'b1;
      while (VALID_OUT !== 1'b1 && k < 40) begin
         if (VALUES_OUT !== exp_a) stable = 1'b0;
         tick;
         k++;
      end
      checks++;
      if (k !== 16) begin errors++; $display("FAIL b2b_second_latency: got %0d want 16", k); end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL b2b_hold: outputs moved between completions"); end
      checks++;
      if (VALUES_OUT !== exp_bus) begin
         errors++; $display("FAIL b2b_second_values: got %h want %h", VALUES_OUT, exp_bus);
      end
   endtask

   task automatic test_reset_mid;
      int pulses;
      tick;
      for (int i = 0; i < N; i++) begin av[i] = 8'sd40; wv[i] = 8'sd40; end
      set_inputs;
      VALID_IN = 1'b1;
      tick;
      VALID_IN = 1'b0;
      repeat (7) tick;
      #2 RST = 1'b1;
      #1;
      checks++;
      if (VALUES_OUT !== '0 || OVF_MASK_OUT !== '0 || OVERFLOW !== 1'b0 ||
          VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
         errors++;
         $display("FAIL midreset_outputs: vals=%h mask=%h ovf=%b vld=%b rdy=%b",
                  VALUES_OUT, OVF_MASK_OUT, OVERFLOW, VALID_OUT, READY_OUT);
      end
      tick;
      RST = 1'b0;
      pulses = 0;
      repeat (20) begin
         tick;
         if (VALID_OUT === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || READY_OUT !== 1'b1) begin
         errors++; $display("FAIL midreset_abort: pulses=%0d rdy=%b want 0/1", pulses, READY_OUT);
      end
      for (int i = 0; i < N; i++) begin av[i] = 8'(3 * i - 20); wv[i] = -8'sd9; end
      set_inputs;
      run_vec(1'b0);
      checks++;
      if (lat !== 16 || VALUES_OUT !== exp_bus || OVF_MASK_OUT !== exp_mask) begin
         errors++; $display("FAIL midreset_fresh: lat=%0d got %h want %h", lat, VALUES_OUT, exp_bus);
      end
   endtask

   task automatic test_stability;
      logic [N*W-1:0] held;
      bit stable;
      tick;
      for (int i = 0; i < N; i++) begin av[i] = 8'(17 * i + 5); wv[i] = 8'(100 - 13 * i); end
      set_inputs;
      held = exp_bus;
      run_vec(1'b1);
      checks++;
      if (lat !== 16 || VALUES_OUT !== held || OVF_MASK_OUT !== exp_mask) begin
         errors++; $display("FAIL stab_latched: lat=%0d got %h want %h", lat, VALUES_OUT, held);
      end
      stable = 1'b1;
      repeat (20) begin
         VALUES_IN  = {$urandom, $urandom, $urandom, $urandom};
         WEIGHTS_IN = {$urandom, $urandom, $urandom, $urandom};
         tick;
         if (VALUES_OUT !== held || VALID_OUT !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL stab_idle_hold: outputs moved while idle"); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_sign;
      test_overflow;
      test_back_to_back;
      test_reset_mid;
      test_stability;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
